// File: rtl/systolic_array_driver.sv
// Host-side streaming engine for an NxN systolic multiplier: buffers A and B, streams
// column k of A / row k of B per cycle, then collects the N result rows of C.
module systolic_array_driver #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    parameter int TIMEOUT   = 64,
    localparam int IDXW     = $clog2(N_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_we,
    input  logic                                 load_sel,
    input  logic [IDXW-1:0]                      load_row,
    input  logic [IDXW-1:0]                      load_col,
    input  logic [DATAWIDTH-1:0]                 load_data,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_timeout,
    output logic                                 arr_valid_in,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]     arr_a_out,
    output logic [N_SIZE-1:0][DATAWIDTH-1:0]     arr_b_out,
    input  logic                                 arr_valid_out,
    input  logic [N_SIZE-1:0][2*DATAWIDTH-1:0]   arr_c_in,
    input  logic [IDXW-1:0]                      rd_row,
    input  logic [IDXW-1:0]                      rd_col,
    output logic [2*DATAWIDTH-1:0]               rd_data
);

    localparam int              TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST  = IDXW'(N_SIZE - 1);
    localparam logic [IDXW:0]   NLIM  = (IDXW + 1)'(N_SIZE);

    typedef logic [N_SIZE-1:0][DATAWIDTH-1:0] lane_t;
    typedef enum logic [1:0] {IDLE, STREAM, WAIT, COLLECT} state_t;

    state_t          state, state_next;
    logic [IDXW-1:0] idx, idx_next, kk;
    logic [TW-1:0]   tcnt, tcnt_next;
    logic            busy_next, done_next, err_next, valid_next;
    logic            issue, c_we, load_ok, rd_ok;
    lane_t           a_next, b_next;

    // a_buf/b_buf are indexed [row][col]; c_buf holds one packed result row per entry
    lane_t                              a_buf [N_SIZE];
    lane_t                              b_buf [N_SIZE];
    logic [N_SIZE-1:0][2*DATAWIDTH-1:0] c_buf [N_SIZE];

    assign load_ok = (state == IDLE) && load_we &&
                     ({1'b0, load_row} < NLIM) && ({1'b0, load_col} < NLIM);
    assign rd_ok   = ({1'b0, rd_row} < NLIM) && ({1'b0, rd_col} < NLIM);

    // idx is the stream step k while streaming and the result row r while collecting
    always_comb begin
        state_next = state;
        idx_next   = idx;
        tcnt_next  = tcnt;
        busy_next  = busy;
        done_next  = done;
        err_next   = err_timeout;
        valid_next = 1'b0;
        issue      = 1'b0;
        c_we       = 1'b0;
        kk         = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    idx_next   = '0;
                    tcnt_next  = '0;
                    kk         = '0;
                    issue      = 1'b1;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                end
            end
            STREAM: begin
                if (idx == LAST) begin
                    state_next = WAIT;
                    idx_next   = '0;
                    tcnt_next  = '0;
                end else begin
                    kk         = idx + 1'b1;
                    idx_next   = idx + 1'b1;
                    issue      = 1'b1;
                    valid_next = 1'b1;
                end
            end
            WAIT: begin
                if (arr_valid_out) begin
                    c_we       = 1'b1;
                    idx_next   = idx + 1'b1;
                    state_next = COLLECT;
                end else if (tcnt == TLAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    tcnt_next  = tcnt + 1'b1;
                end
            end
            COLLECT: begin
                if (arr_valid_out) begin
                    c_we = 1'b1;
                    if (idx == LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next   = idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write in the same cycle as start is forwarded so the first lane sees the new value
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (issue) begin
            for (int i = 0; i < N_SIZE; i++) begin
                a_next[i] = a_buf[i][kk];
                b_next[i] = b_buf[kk][i];
                if (load_ok && !load_sel && load_row == IDXW'(i) && load_col == kk)
                    a_next[i] = load_data;
                if (load_ok && load_sel && load_row == kk && load_col == IDXW'(i))
                    b_next[i] = load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            tcnt         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            arr_valid_in <= 1'b0;
            arr_a_out    <= '0;
            arr_b_out    <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            tcnt         <= tcnt_next;
            busy         <= busy_next;
            done         <= done_next;
            err_timeout  <= err_next;
            arr_valid_in <= valid_next;
            arr_a_out    <= a_next;
            arr_b_out    <= b_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SIZE; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
                c_buf[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (load_ok && !load_sel)
                a_buf[load_row][load_col] <= load_data;
            if (load_ok && load_sel)
                b_buf[load_row][load_col] <= load_data;
            if (c_we)
                c_buf[idx] <= arr_c_in;
            rd_data <= rd_ok ? c_buf[rd_row][rd_col] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_array_driver.sv
// Self-checking bench for systolic_array_driver (N_SIZE=3, TIMEOUT=8) with a lane
// scoreboard, a behavioural array model and a C read-back scoreboard.
module tb_systolic_array_driver;

    localparam int DW = 16;
    localparam int N  = 3;
    localparam int TO = 8;

    typedef logic [N-1:0][DW-1:0] lane_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     load_we, load_sel, start, arr_valid_out;
    logic [1:0]               load_row, load_col, rd_row, rd_col;
    logic [DW-1:0]            load_data;
    logic                     busy, done, err_timeout, arr_valid_in;
    lane_t                    arr_a_out, arr_b_out;
    logic [N-1:0][2*DW-1:0]   arr_c_in;
    logic [2*DW-1:0]          rd_data;

    int vectors     = 0;
    int miscompares = 0;

    logic signed [DW-1:0]   ma [N][N];
    logic signed [DW-1:0]   mb [N][N];
    logic signed [2*DW-1:0] acc [N][N];
    logic signed [2*DW-1:0] expc [N][N];
    lane_t                  qa [$];
    lane_t                  qb [$];
    logic [2*DW-1:0]        qc [$];

    systolic_array_driver #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_sel(load_sel), .load_row(load_row), .load_col(load_col),
        .load_data(load_data), .start(start),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .arr_valid_in(arr_valid_in), .arr_a_out(arr_a_out), .arr_b_out(arr_b_out),
        .arr_valid_out(arr_valid_out), .arr_c_in(arr_c_in),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic load_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    load_we   = 1'b1;
                    load_sel  = s[0];
                    load_row  = 2'(i);
                    load_col  = 2'(j);
                    load_data = (s == 1) ? mb[i][j] : ma[i][j];
                end
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic compute_expected();
        logic signed [2*DW-1:0] pa, pb;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                expc[i][j] = '0;
                for (int k = 0; k < N; k++) begin
                    pa = 32'(ma[i][k]);
                    pb = 32'(mb[k][j]);
                    expc[i][j] = expc[i][j] + pa * pb;
                end
            end
    endtask

    task automatic randomize_mats();
        int v;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                v = int'($urandom_range(40)) - 20;
                ma[i][j] = 16'(v);
                v = int'($urandom_range(40)) - 20;
                mb[i][j] = 16'(v);
            end
    endtask

    // Caller is at a negedge; start is driven now. The array model accumulates the
    // lanes the DUT actually streams, as a real array would.
    task automatic run_stream(input bit inject, input bit same_write);
        lane_t la, lb, ea, eb;
        logic signed [2*DW-1:0] pa, pb;
        start = 1'b1;
        if (same_write) begin
            load_we = 1'b1; load_sel = 1'b0; load_row = 2'd1; load_col = 2'd0;
            load_data = 16'd7;
            ma[1][0] = 16'sd7;
        end
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                la[i] = ma[i][k];
                lb[i] = mb[k][i];
            end
            qa.push_back(la);
            qb.push_back(lb);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                acc[i][j] = '0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            start = 1'b0;
            load_we = 1'b0;
            if (inject && k == 1) begin
                start = 1'b1; load_we = 1'b1; load_sel = 1'b0;
                load_row = 2'd0; load_col = 2'd0; load_data = 16'd99;
            end
            ea = qa.pop_front();
            eb = qb.pop_front();
            vectors++;
            if ({arr_valid_in, busy, done, err_timeout} !== 4'b1100) begin
                miscompares++;
                $display("[TB] FAIL stream_ctrl k=%0d: got v/b/d/e=%b expected 1100", k,
                         {arr_valid_in, busy, done, err_timeout});
            end
            vectors++;
            if (arr_a_out !== ea) begin
                miscompares++;
                $display("[TB] FAIL stream_a k=%0d: got %h expected %h", k, arr_a_out, ea);
            end
            vectors++;
            if (arr_b_out !== eb) begin
                miscompares++;
                $display("[TB] FAIL stream_b k=%0d: got %h expected %h", k, arr_b_out, eb);
            end
            if (arr_valid_in === 1'b1)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        pa = 32'($signed(arr_a_out[i]));
                        pb = 32'($signed(arr_b_out[j]));
                        acc[i][j] = acc[i][j] + pa * pb;
                    end
        end
        @(negedge clk);
        start = 1'b0;
        load_we = 1'b0;
        vectors++;
        if (arr_valid_in !== 1'b0 || arr_a_out !== '0 || arr_b_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL stream_drop: got v=%b a=%h b=%h expected 0/0/0",
                     arr_valid_in, arr_a_out, arr_b_out);
        end
    endtask

    // Drives arr_valid_out per pattern bit (bit 0 first); idle cycles carry junk data.
    task automatic return_rows(input logic [7:0] pattern, input int len);
        int nv = 0;
        for (int p = 0; p < len; p++) begin
            arr_valid_out = pattern[p];
            for (int j = 0; j < N; j++)
                arr_c_in[j] = (pattern[p] && nv < N) ? acc[nv][j] : 32'hDEAD_BEEF;
            @(negedge clk);
            if (pattern[p]) nv++;
            vectors++;
            if (done !== 1'(nv == N)) begin
                miscompares++;
                $display("[TB] FAIL collect_done step=%0d: got %b expected %b", p, done, nv == N);
            end
        end
        arr_valid_out = 1'b0;
        vectors++;
        if (busy !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL collect_end: got busy=%b err=%b expected 0/0", busy, err_timeout);
        end
    endtask

    // Address changes every cycle and rd_data is checked just after, so a read
    // that is not registered shows the wrong element.
    task automatic read_check();
        logic [2*DW-1:0] e;
        for (int n = 0; n <= N * N; n++) begin
            if (n < N * N) begin
                rd_row = 2'(n / N);
                rd_col = 2'(n % N);
                qc.push_back(expc[n / N][n % N]);
            end
            #1;
            if (n > 0) begin
                e = qc.pop_front();
                vectors++;
                if (rd_data !== e) begin
                    miscompares++;
                    $display("[TB] FAIL read_c idx=%0d: got %0d expected %0d", n - 1,
                             $signed(rd_data), $signed(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, err_timeout, arr_valid_in} !== 4'b0000 ||
            arr_a_out !== '0 || arr_b_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got b/d/e/v=%b a=%h b=%h expected zeros",
                     {busy, done, err_timeout, arr_valid_in}, arr_a_out, arr_b_out);
        end
        rd_row = 2'd1; rd_col = 2'd1;
        @(negedge clk);
        vectors++;
        if (rd_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_end_to_end();
        ma = '{'{2, -1, 4}, '{5, 2, -2}, '{-4, 3, 0}};
        mb = '{'{3, 1, -2}, '{-1, 2, 5}, '{2, 3, 0}};
        load_all();
        run_stream(1'b0, 1'b0);
        return_rows(8'b111, 3);
        expc = '{'{15, 12, -9}, '{9, 3, 0}, '{-15, 2, 23}};
        read_check();
    endtask

    task automatic test_gapped_collect();
        ma = '{'{3, 1, -2}, '{-1, 2, 5}, '{2, 3, 0}};
        mb = '{'{2, -1, 4}, '{5, 2, -2}, '{-4, 3, 0}};
        load_all();
        run_stream(1'b0, 1'b0);
        return_rows(8'b11001, 5);
        compute_expected();
        read_check();
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (arr_valid_in !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrun_pre: got v=%b busy=%b expected 1/1", arr_valid_in, busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({arr_valid_in, busy, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL midrun_async: got v/b/d=%b expected 000",
                     {arr_valid_in, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        ma = '{default: '{default: '0}};
        mb = '{default: '{default: '0}};
        compute_expected();
        read_check();
    endtask

    task automatic test_timeout();
        run_stream(1'b0, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'(i == TO) || err_timeout !== 1'(i == TO)) begin
                miscompares++;
                $display("[TB] FAIL timeout_cycle %0d: got done=%b err=%b expected %b",
                         i, done, err_timeout, i == TO);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_ignored_inputs();
        randomize_mats();
        ma[1][0] = -16'sd3;
        load_all();
        run_stream(1'b1, 1'b0);
        return_rows(8'b111, 3);
        compute_expected();
        read_check();
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (arr_valid_in !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL second_run: got v=%b busy=%b expected 0/0",
                         arr_valid_in, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, 1'b0);
        return_rows(8'b111, 3);
        run_stream(1'b0, 1'b1);
        return_rows(8'b1101, 4);
        compute_expected();
        read_check();
    endtask

    initial begin
        rst = 1'b1; load_we = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
        load_data = '0; start = 1'b0; arr_valid_out = 1'b0; arr_c_in = '0;
        rd_row = '0; rd_col = '0;
        test_reset();
        test_end_to_end();
        test_gapped_collect();
        test_reset_midrun();
        test_timeout();
        test_ignored_inputs();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
